rdm_combine_ram: RTL and testbench
==================================

# rdm_combine_ram

Parametrised single-clock dual-port buffer for the rate-dematching datapath. It stores LANES signed soft-bit lanes per word, with per-lane write enables. Each write either overwrites the enabled lanes or saturating-adds into them (HARQ soft combining), with read-modify-write hazard forwarding. A built-in clear engine zeroes the whole array before a new transport block.

## Interface
Parameters:
- LANES, 144, lanes per word
- LANE_W, 8, bits per lane (signed two's complement)
- DEPTH, 2048, words
- AW, $clog2(DEPTH), address width (11 at default)
- RD_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
- sclk  in  1  clock; everything is single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- wr_vld  in  1  write request
- wr_rdy  out  1  write accept; a write is accepted when wr_vld & wr_rdy
- wr_mode  in  1  0 = overwrite, 1 = combine (saturating add)
- wr_addr  in  AW  write address
- wr_be  in  LANES  per-lane enable; lane i = bits [i*LANE_W +: LANE_W]
- wr_data  in  LANES*LANE_W  write data
- rd_vld  in  1  read request; always accepted
- rd_addr  in  AW  read address
- rd_data  out  LANES*LANE_W  read data
- rd_dout_vld  out  1  rd_data valid strobe
- clr_start  in  1  clear request pulse
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write

## Operation
- Storage is an inferred RAM array. It is not reset.
- Reset values: rd_data = 0, rd_dout_vld = 0, clr_busy = 0, clr_done = 0. wr_rdy = 1 (state IDLE).
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clr_start = 1. clr_start is ignored while in CLEAR.
  - CLEAR -> IDLE after the write to address DEPTH-1. clr_done pulses in the first IDLE cycle.
- wr_rdy = (state == IDLE) & ~clr_start, combinational. A write presented in the same cycle as clr_start is not accepted.
- Write pipeline:
  - W0 (accept cycle): issue the RAM read of wr_addr; register addr, be, data and mode.
  - W1 (next cycle): form the new word, then commit at the end of W1.
  - Overwrite mode: enabled lanes take wr_data; disabled lanes keep the old value.
  - Combine mode: enabled lanes take sat(old + new). Disabled lanes are unchanged.
- Saturation: form the (LANE_W+1)-bit sum, then clamp to [-2^(LANE_W-1), 2^(LANE_W-1)-1].
- Forwarding: the "old" word in W1 must reflect every previously committed write, including one committed at the end of the immediately preceding cycle. Back-to-back writes to the same address must combine cumulatively, with no lost update.
- Clear engine:
  - Writes all-zero words to addresses 0..DEPTH-1, one per cycle, all lanes.
  - clr_busy is high for exactly DEPTH cycles.
  - A W1 write already in flight when clr_start is asserted commits before the first clear write.
- Reads:
  - Accepted in any state, including during CLEAR.
  - Collision policy is read-first: a read sees writes committed before the clock edge that ends its issue cycle.
  - Consequently a read issued in cycle t returns every write accepted in cycle ≤ t-2. It does not see a write accepted in t-1.
- rd_data holds its last value while rd_dout_vld = 0.
- Reset mid-operation: the FSM returns to IDLE and all pipeline valids clear. Any in-flight write or clear is abandoned, leaving RAM contents partially updated; software must re-clear.

## Timing
- Write: accepted at cycle t, committed at the end of t+1. Sustained throughput is one write per cycle in IDLE.
- Read: issued at t. rd_data and rd_dout_vld are registered outputs, valid at t+RD_LAT. Throughput is one read per cycle.
- Clear: clr_start at cycle c. Clear writes occur in c+1..c+DEPTH. clr_busy is high over c+1..c+DEPTH. clr_done is high at c+DEPTH+1. wr_rdy is low over c..c+DEPTH.
- Simultaneous read and write at the same address in the same cycle: the read returns pre-write data.

## Test plan
- Reset then clear: assert clr_start and wait for clr_done, DEPTH+1 cycles later. Read addresses 0, 1023 and 2047 -> all 0x00 lanes, rd_dout_vld exactly RD_LAT cycles after each rd_vld.
- Overwrite with partial be: write 0xAA to all lanes at 100, then 0x55 with wr_be = lanes 0..139 only. Read 100 -> lanes 0..139 = 0x55, lanes 140..143 = 0xAA.
- Combine saturation:
  - At 5, overwrite 0x70, then combine 0x20 -> 0x7F.
  - At 6, overwrite 0x80, then combine 0xF0 -> 0x80.
  - At 7, overwrite 0x10, then combine 0xFE -> 0x0E.
- Hazard: four back-to-back combine writes of 0x01 to address 9 after clear -> read gives 0x04 in every lane. Repeat with idle gaps of 1 cycle -> same result.
- Read-first collision: with 0x11 stored at 42, write 0x22 at cycle t and read 42 at t, t+1 and t+2 -> 0x11, 0x11, 0x22.
- Clear interplay: clr_start together with wr_vld -> write not accepted and wr_rdy low. Assert rst_n = 0 mid-clear -> clr_busy = 0 and wr_rdy = 1 immediately after reset release. Repeat with RD_LAT = 2.

Source files
------------

// File: rtl/rdm_combine_ram.sv
// Soft-bit word buffer: per-lane overwrite or saturating combine, hazard-forwarded RMW, built-in clear engine.
// Latency: write commits one cycle after accept; read data valid RD_LAT cycles after issue. wr_rdy drops during clear.
module rdm_combine_ram #(
    parameter int LANES  = 144,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 2048,
    parameter int AW     = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic                    sclk,
    input  logic                    rst_n,
    input  logic                    wr_vld,
    output logic                    wr_rdy,
    input  logic                    wr_mode,
    input  logic [AW-1:0]           wr_addr,
    input  logic [LANES-1:0]        wr_be,
    input  logic [LANES*LANE_W-1:0] wr_data,
    input  logic                    rd_vld,
    input  logic [AW-1:0]           rd_addr,
    output logic [LANES*LANE_W-1:0] rd_data,
    output logic                    rd_dout_vld,
    input  logic                    clr_start,
    output logic                    clr_busy,
    output logic                    clr_done
);
    localparam int W = LANES * LANE_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state;
    logic [AW-1:0]   clr_addr;
    logic [W-1:0]    mem [DEPTH];

    logic            wr_acc;
    logic            w1_vld;
    logic            w1_mode;
    logic [AW-1:0]   w1_addr;
    logic [LANES-1:0] w1_be;
    logic [W-1:0]    w1_data;
    logic [W-1:0]    w1_old;
    logic [W-1:0]    w1_word;

    logic            commit_en;
    logic [AW-1:0]   commit_addr;
    logic [W-1:0]    commit_word;

    function automatic logic [LANE_W-1:0] sat_add(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
        logic [LANE_W:0] s;
        s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        if (s[LANE_W] != s[LANE_W-1])
            return s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        return s[LANE_W-1:0];
    endfunction

    assign wr_rdy = (state == IDLE) && !clr_start;
    assign wr_acc = wr_vld && wr_rdy;

    always_comb begin
        w1_word = w1_old;
        for (int i = 0; i < LANES; i++) begin
            if (w1_be[i])
                w1_word[i*LANE_W +: LANE_W] = w1_mode
                    ? sat_add(w1_old[i*LANE_W +: LANE_W], w1_data[i*LANE_W +: LANE_W])
                    : w1_data[i*LANE_W +: LANE_W];
        end
    end

    // Clear writes and W1 commits never overlap: no write is accepted in the clr_start cycle.
    assign commit_en   = w1_vld || (state == CLEAR);
    assign commit_addr = (state == CLEAR) ? clr_addr : w1_addr;
    assign commit_word = (state == CLEAR) ? '0 : w1_word;

    always_ff @(posedge sclk) begin
        if (commit_en)
            mem[commit_addr] <= commit_word;
    end

    // The RAM read in W0 misses a commit on the same edge; forward it so consecutive combines accumulate.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            w1_vld  <= 1'b0;
            w1_mode <= 1'b0;
            w1_addr <= '0;
            w1_be   <= '0;
            w1_data <= '0;
            w1_old  <= '0;
        end else begin
            w1_vld <= wr_acc;
            if (wr_acc) begin
                w1_mode <= wr_mode;
                w1_addr <= wr_addr;
                w1_be   <= wr_be;
                w1_data <= wr_data;
                w1_old  <= (commit_en && commit_addr == wr_addr) ? commit_word : mem[wr_addr];
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            clr_addr <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                        clr_addr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_addr == AW'(DEPTH - 1)) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (RD_LAT == 1) begin : g_rd1
            always_ff @(posedge sclk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data     <= '0;
                    rd_dout_vld <= 1'b0;
                end else begin
                    rd_dout_vld <= rd_vld;
                    if (rd_vld)
                        rd_data <= mem[rd_addr];
                end
            end
        end else begin : g_rd2
            logic         r1_vld;
            logic [W-1:0] r1_data;
            always_ff @(posedge sclk or negedge rst_n) begin
                if (!rst_n) begin
                    r1_vld      <= 1'b0;
                    r1_data     <= '0;
                    rd_data     <= '0;
                    rd_dout_vld <= 1'b0;
                end else begin
                    r1_vld      <= rd_vld;
                    rd_dout_vld <= r1_vld;
                    if (rd_vld)
                        r1_data <= mem[rd_addr];
                    if (r1_vld)
                        rd_data <= r1_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rdm_combine_ram.sv
// Bench for rdm_combine_ram: two instances (RD_LAT 1 and 2) on shared stimulus, checked against a lane-level array model.
module tb_rdm_combine_ram;
    localparam int LANES  = 144;
    localparam int LANE_W = 8;
    localparam int DEPTH  = 2048;
    localparam int AW     = 11;
    localparam int W      = LANES * LANE_W;

    logic tb_sclk = 1'b0;
    always #5 tb_sclk = ~tb_sclk;

    logic             rst_n;
    logic             wr_vld, wr_mode, rd_vld, clr_start;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [LANES-1:0] wr_be;
    logic [W-1:0]     wr_data;

    logic             wr_rdy1, rd_vld1, busy1, done1;
    logic             wr_rdy2, rd_vld2, busy2, done2;
    logic [W-1:0]     rd_data1, rd_data2;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] model [DEPTH];

    rdm_combine_ram #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .AW(AW), .RD_LAT(1)) u_dut1 (
        .sclk(tb_sclk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_rdy(wr_rdy1), .wr_mode(wr_mode),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .rd_vld(rd_vld), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_dout_vld(rd_vld1), .clr_start(clr_start), .clr_busy(busy1),
        .clr_done(done1));

    rdm_combine_ram #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .AW(AW), .RD_LAT(2)) u_dut2 (
        .sclk(tb_sclk), .rst_n(rst_n), .wr_vld(wr_vld), .wr_rdy(wr_rdy2), .wr_mode(wr_mode),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .rd_vld(rd_vld), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_dout_vld(rd_vld2), .clr_start(clr_start), .clr_busy(busy2),
        .clr_done(done2));

    task automatic tick();
        @(posedge tb_sclk);
        #1;
    endtask

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        logic [W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*8 +: 8] = b;
        return w;
    endfunction

    function automatic logic [LANES-1:0] be_low(input int n);
        logic [LANES-1:0] be;
        for (int i = 0; i < LANES; i++) be[i] = (i < n);
        return be;
    endfunction

    function automatic logic [7:0] sat(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < LANES; i++)
            if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        return 0;
    endfunction

    // Model applies a write in full at its accept; reads are issued only after it is visible.
    task automatic model_write(input int a, input logic [LANES-1:0] be, input logic [W-1:0] d,
                               input logic mode);
        for (int i = 0; i < LANES; i++)
            if (be[i])
                model[a][i*8 +: 8] = mode ? sat(model[a][i*8 +: 8], d[i*8 +: 8]) : d[i*8 +: 8];
    endtask

    task automatic do_write(input int a, input logic [LANES-1:0] be, input logic [W-1:0] d,
                            input logic mode);
        wr_vld  = 1'b1;
        wr_addr = AW'(a);
        wr_be   = be;
        wr_data = d;
        wr_mode = mode;
        tick();
        wr_vld = 1'b0;
        model_write(a, be, d, mode);
    endtask

    // One idle cycle first so any write issued just before is visible to the read.
    task automatic do_read(input int a, output logic [W-1:0] d1, output logic [W-1:0] d2,
                           output logic lat_ok);
        tick();
        rd_vld  = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_vld = 1'b0;
        d1     = rd_data1;
        lat_ok = (rd_vld1 === 1'b1) && (rd_vld2 === 1'b0);
        tick();
        d2     = rd_data2;
        lat_ok = lat_ok && (rd_vld2 === 1'b1) && (rd_vld1 === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_vld = 0; rd_vld = 0; clr_start = 0; wr_mode = 0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        repeat (3) tick();
        checks++;
        if ({rd_data1, rd_data2} !== '0 || {rd_vld1, rd_vld2} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rd got vld=%b%b want 00 and zero data", rd_vld1, rd_vld2);
        end
        checks++;
        if ({busy1, busy2, done1, done2} !== 4'b0000 || {wr_rdy1, wr_rdy2} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ctl got busy=%b%b done=%b%b rdy=%b%b want 0000 11",
                     busy1, busy2, done1, done2, wr_rdy1, wr_rdy2);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({wr_rdy1, wr_rdy2, busy1, busy2} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release got rdy=%b%b busy=%b%b want 11 00",
                     wr_rdy1, wr_rdy2, busy1, busy2);
        end
    endtask

    task automatic test_clear(input logic with_write);
        int n, busy_cnt, rdy_cnt;
        logic [W-1:0] d1, d2;
        logic ok;
        int addrs [4] = '{0, 1023, 2047, 3};
        clr_start = 1'b1;
        wr_vld    = with_write;
        wr_addr   = AW'(3);
        wr_be     = '1;
        wr_data   = rep(8'h5A);
        wr_mode   = 1'b0;
        #1;
        checks++;
        if ({wr_rdy1, wr_rdy2} !== 2'b00) begin
            errors++;
            $display("FAIL clr_start_rdy got %b%b want 00", wr_rdy1, wr_rdy2);
        end
        tick();
        clr_start = 1'b0;
        wr_vld    = 1'b0;
        n = 0; busy_cnt = 0; rdy_cnt = 0;
        while (done1 !== 1'b1 && n < DEPTH + 10) begin
            if (busy1 === 1'b1 && busy2 === 1'b1) busy_cnt++;
            if (wr_rdy1 !== 1'b0 || wr_rdy2 !== 1'b0) rdy_cnt++;
            tick();
            n++;
        end
        checks++;
        if (n != DEPTH || busy_cnt != DEPTH || rdy_cnt != 0 || done2 !== 1'b1) begin
            errors++;
            $display("FAIL clear_timing got done_after=%0d busy=%0d rdy_hi=%0d done2=%b want %0d %0d 0 1",
                     n, busy_cnt, rdy_cnt, done2, DEPTH, DEPTH);
        end
        tick();
        checks++;
        if ({done1, done2, busy1, busy2} !== 4'b0000) begin
            errors++;
            $display("FAIL clear_done_pulse got done=%b%b busy=%b%b want 0000", done1, done2, busy1, busy2);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int k = 0; k < 4; k++) begin
            do_read(addrs[k], d1, d2, ok);
            checks++;
            if (d1 !== model[addrs[k]] || d2 !== model[addrs[k]] || !ok) begin
                errors++;
                $display("FAIL clear_read addr %0d lane %0d got %h/%h lat_ok=%b want 00 lat_ok=1",
                         addrs[k], first_diff(d1 | d2, '0), d1[first_diff(d1 | d2, '0)*8 +: 8],
                         d2[first_diff(d1 | d2, '0)*8 +: 8], ok);
            end
        end
    endtask

    task automatic test_overwrite_be();
        logic [W-1:0] d1, d2;
        logic ok;
        do_write(100, '1, rep(8'hAA), 1'b0);
        do_write(100, be_low(140), rep(8'h55), 1'b0);
        do_read(100, d1, d2, ok);
        checks++;
        if (d1 !== model[100] || d2 !== model[100] || !ok) begin
            errors++;
            $display("FAIL overwrite_be lane %0d got %h want %h lat_ok=%b", first_diff(d1, model[100]),
                     d1[first_diff(d1, model[100])*8 +: 8], model[100][first_diff(d1, model[100])*8 +: 8], ok);
        end
        checks++;
        if (d1[139*8 +: 8] !== 8'h55 || d1[140*8 +: 8] !== 8'hAA || d2[143*8 +: 8] !== 8'hAA) begin
            errors++;
            $display("FAIL overwrite_be_edge got %h %h %h want 55 aa aa",
                     d1[139*8 +: 8], d1[140*8 +: 8], d2[143*8 +: 8]);
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] d1, d2;
        logic ok;
        logic [7:0] want [3] = '{8'h7F, 8'h80, 8'h0E};
        do_write(5, '1, rep(8'h70), 1'b0);
        do_write(5, '1, rep(8'h20), 1'b1);
        do_write(6, '1, rep(8'h80), 1'b0);
        do_write(6, '1, rep(8'hF0), 1'b1);
        do_write(7, '1, rep(8'h10), 1'b0);
        do_write(7, '1, rep(8'hFE), 1'b1);
        for (int k = 0; k < 3; k++) begin
            do_read(5 + k, d1, d2, ok);
            checks++;
            if (d1 !== model[5+k] || d2 !== model[5+k] || d1 !== rep(want[k]) || !ok) begin
                errors++;
                $display("FAIL saturation addr %0d got %h/%h want %h lat_ok=%b",
                         5 + k, d1[first_diff(d1, rep(want[k]))*8 +: 8],
                         d2[first_diff(d2, rep(want[k]))*8 +: 8], want[k], ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d1, d2;
        logic ok;
        for (int k = 0; k < 4; k++) do_write(9, '1, rep(8'h01), 1'b1);
        for (int k = 0; k < 4; k++) begin
            do_write(10, '1, rep(8'h01), 1'b1);
            tick();
        end
        for (int a = 9; a <= 10; a++) begin
            do_read(a, d1, d2, ok);
            checks++;
            if (d1 !== model[a] || d2 !== model[a] || d1 !== rep(8'h04) || !ok) begin
                errors++;
                $display("FAIL hazard addr %0d got %h/%h want 04 lat_ok=%b",
                         a, d1[first_diff(d1, rep(8'h04))*8 +: 8], d2[first_diff(d2, rep(8'h04))*8 +: 8], ok);
            end
        end
    endtask

    task automatic test_collision();
        logic [7:0] want [3] = '{8'h11, 8'h11, 8'h22};
        do_write(42, '1, rep(8'h11), 1'b0);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            rd_vld  = 1'b1;
            rd_addr = AW'(42);
            if (k == 0) begin
                wr_vld = 1'b1; wr_addr = AW'(42); wr_be = '1; wr_data = rep(8'h22); wr_mode = 1'b0;
            end
            tick();
            wr_vld = 1'b0;
            checks++;
            if (rd_data1 !== rep(want[k]) || (k > 0 && rd_data2 !== rep(want[k-1]))) begin
                errors++;
                $display("FAIL collision read t+%0d got %h/%h want %h", k,
                         rd_data1[7:0], rd_data2[7:0], want[k]);
            end
        end
        rd_vld = 1'b0;
        tick();
        checks++;
        if (rd_data2 !== rep(want[2]) || rd_vld2 !== 1'b1) begin
            errors++;
            $display("FAIL collision dut2 last got %h vld=%b want 22 1", rd_data2[7:0], rd_vld2);
        end
        model_write(42, '1, rep(8'h22), 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] d1, d2, d;
        logic [LANES-1:0] be;
        logic ok;
        int bad;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < LANES; i++) begin
                be[i]      = 1'($urandom_range(0, 1));
                d[i*8 +: 8] = 8'($urandom);
            end
            do_write(200 + $urandom_range(0, 15), be, d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) tick();
        end
        bad = 0;
        for (int a = 200; a < 216; a++) begin
            do_read(a, d1, d2, ok);
            checks++;
            if (d1 !== model[a] || d2 !== model[a] || !ok) begin
                errors++;
                bad++;
                $display("FAIL random addr %0d lane %0d got %h want %h lat_ok=%b", a,
                         first_diff(d1, model[a]), d1[first_diff(d1, model[a])*8 +: 8],
                         model[a][first_diff(d1, model[a])*8 +: 8], ok);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (100) tick();
        checks++;
        if ({busy1, busy2} !== 2'b11) begin
            errors++;
            $display("FAIL mid_clear_busy got %b%b want 11", busy1, busy2);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, busy2, done1, done2} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_clear_reset got busy=%b%b done=%b%b want 0000", busy1, busy2, done1, done2);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({wr_rdy1, wr_rdy2, busy1, busy2} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_clear_release got rdy=%b%b busy=%b%b want 11 00", wr_rdy1, wr_rdy2, busy1, busy2);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_clear(1'b0);
        test_overwrite_be();
        test_saturation();
        test_back_to_back();
        test_collision();
        test_random();
        test_clear(1'b1);
        test_reset_mid_clear();
        test_clear(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
